// File: rtl/kgp_seg_display.sv
// kgp_seg_display: 4-digit common-anode hex display for the KGPRISC out port.
// Optional LEADING_ZERO_BLANK_EN macro darkens digits above the top nonzero nibble.
module kgp_seg_display #(
  parameter int REFRESH_CNT = 100000,
  localparam int CNT_W = $clog2(REFRESH_CNT)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        freeze,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(REFRESH_CNT - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      shadow;

  logic             term;
  logic             cap;
  logic [3:0]       nib;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;
  logic             dark;

  // terminal count and capture strobe
  always_comb begin
    term = (cnt == TERM);
    cap  = term && (idx == 2'd3) && !freeze;
  end

  // refresh counter and digit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (term) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // shadow copy, loaded only as a sweep completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= 16'h0000;
    end else if (cap) begin
      shadow <= data_in;
    end
  end

  // pick the nibble of the digit being lit
  always_comb begin
    nib = 4'h0;
    unique case (idx)
      2'd0: nib = shadow[3:0];
      2'd1: nib = shadow[7:4];
      2'd2: nib = shadow[11:8];
      2'd3: nib = shadow[15:12];
    endcase
  end

  // hex to cathode pattern, gfedcba, active-low
  always_comb begin
    seg_nxt = 7'b1111111;
    unique case (nib)
      4'h0: seg_nxt = 7'b1000000;
      4'h1: seg_nxt = 7'b1111001;
      4'h2: seg_nxt = 7'b0100100;
      4'h3: seg_nxt = 7'b0110000;
      4'h4: seg_nxt = 7'b0011001;
      4'h5: seg_nxt = 7'b0010010;
      4'h6: seg_nxt = 7'b0000010;
      4'h7: seg_nxt = 7'b1111000;
      4'h8: seg_nxt = 7'b0000000;
      4'h9: seg_nxt = 7'b0010000;
      4'hA: seg_nxt = 7'b0001000;
      4'hB: seg_nxt = 7'b0000011;
      4'hC: seg_nxt = 7'b1000110;
      4'hD: seg_nxt = 7'b0100001;
      4'hE: seg_nxt = 7'b0000110;
      4'hF: seg_nxt = 7'b0001110;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0] msd;

  // highest nonzero digit; digit 0 always counts as lit
  always_comb begin
    msd = 2'd0;
    unique case (1'b1)
      (|shadow[15:12]):
        msd = 2'd3;
      (~|shadow[15:12] && |shadow[11:8]):
        msd = 2'd2;
      (~|shadow[15:8] && |shadow[7:4]):
        msd = 2'd1;
      default:
        msd = 2'd0;
    endcase
  end

  // leading zeros go dark but keep their slot
  always_comb begin
    dark = (idx > msd);
  end
`else
  // every digit lit
  always_comb begin
    dark = 1'b0;
  end
`endif

  // anode select and freeze indicator
  always_comb begin
    an_nxt = 4'b1111;
    unique case (idx)
      2'd0: an_nxt = 4'b1110;
      2'd1: an_nxt = 4'b1101;
      2'd2: an_nxt = 4'b1011;
      2'd3: an_nxt = 4'b0111;
    endcase
    if (blank || dark) begin
      an_nxt = 4'b1111;
    end
    dp_nxt = !(freeze && (idx == 2'd0));
  end

  // registered outputs, one clock behind the index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_kgp_seg_display.sv
// tb_kgp_seg_display: directed checks of the multiplexed hex display.
// Build with +define+LEADING_ZERO_BLANK_EN to cover leading-zero blanking.
module tb_kgp_seg_display;

`ifdef LEADING_ZERO_BLANK_EN
  localparam int TOP0  = 0;
  localparam int TOP30 = 1;
`else
  localparam int TOP0  = 3;
  localparam int TOP30 = 3;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic        freeze;
  logic        blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_chk;
  int n_fail;
  int k;

  kgp_seg_display #(.REFRESH_CNT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .freeze  (freeze),
    .blank   (blank),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] segtab(
    input logic [3:0] n
  );
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%h expected=%h",
             tag, k, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_an"},  16'(an),  16'hf);
    chk({tag, "_seg"}, 16'(seg), 16'h7f);
    chk({tag, "_dp"},  16'(dp),  16'h1);
  endtask

  // val: shadow value on display; top: highest lit digit
  task automatic sweep(
    input int          n,
    input logic [15:0] val,
    input int          top
  );
    int         d;
    logic [3:0] ea;
    logic [3:0] nb;
    for (int i = 0; i < n; i++) begin
      tick();
      d  = ((k - 1) / 4) % 4;
      ea = ~(4'b0001 << d);
      if (blank || d > top) ea = 4'b1111;
      nb = 4'((val >> (4 * d)) & 16'hf);
      chk("an", 16'(an), 16'(ea));
      if (ea != 4'b1111)
        chk("seg", 16'(seg), 16'(segtab(nb)));
      chk("dp", 16'(dp),
          16'(!(freeze && d == 0)));
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    k       = 0;
    rst     = 1'b0;
    data_in = 16'h0000;
    freeze  = 1'b0;
    blank   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_off("rst_hold");

    data_in = 16'h1234;
    @(negedge clk);
    rst = 1'b1;

    sweep(16, 16'h0000, TOP0);
    sweep(16, 16'h1234, 3);

    freeze  = 1'b1;
    data_in = 16'hA5C0;
    sweep(24, 16'h1234, 3);
    freeze  = 1'b0;
    sweep(8, 16'h1234, 3);
    sweep(16, 16'hA5C0, 3);

    sweep(2, 16'hA5C0, 3);
    blank = 1'b1;
    sweep(6, 16'hA5C0, 3);
    blank = 1'b0;
    sweep(18, 16'hA5C0, 3);

    #2;
    rst = 1'b0;
    #1;
    chk_off("rst_async");
    data_in = 16'h0030;
    repeat (2) @(posedge clk);
    #1;
    chk_off("rst_held");
    @(negedge clk);
    rst = 1'b1;
    k   = 0;

    sweep(16, 16'h0000, TOP0);
    data_in = 16'h0000;
    sweep(16, 16'h0030, TOP30);
    sweep(16, 16'h0000, TOP0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kgp_seg_display.md
Name: kgp_seg_display

Overview:
- Downstream consumer of the KGPRISC `out[15:0]` result port.
- Drives the board's 4-digit common-anode seven-segment display, one hex digit per nibble, time-multiplexed.
- Holds a shadow copy of the value so a digit never shows mixed old/new nibbles within one sweep.
- Adds freeze and blank controls, wired to board switches or buttons.

Parameters:
- REFRESH_CNT, 100000: clocks each digit stays lit (1 kHz per digit at 100 MHz). Legal range ≥2; benches use 4.
- CNT_W, $clog2(REFRESH_CNT): refresh counter width. Derived; never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  16  value to display; connects to KGPRISC `out`.
- freeze  in  1  high: shadow register is not updated.
- blank  in  1  high: all anodes off; timing keeps running.
- an  out  4  anode enables, active-low; an[0] = least significant digit.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset (rst low, asynchronous): counter, digit index and shadow register clear to 0. Outputs go to an=4'b1111, seg=7'b1111111, dp=1, and hold while rst is low.
- Refresh counter: counts 0..REFRESH_CNT-1 and wraps to 0.
  - At terminal count, the index advances 0→1→2→3→0.
  - At every other count, the index holds.
- Shadow capture: on the edge where count==REFRESH_CNT-1, index==3 and freeze==0, shadow loads data_in. This is the same edge on which the index wraps to 0. data_in is never sampled at any other time.
- Output register: an, seg and dp are registered decodes of the current (index, shadow, blank, freeze), so they lag the index by exactly one clock.
  - an = one-hot-low of the index, or 4'b1111 if blank.
  - seg = decode of shadow nibble[index].
  - dp = 0 only when freeze==1 and index==0; otherwise 1.
- Decode table, nibble→seg (gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Freeze asserted mid-sweep: takes effect at the next capture edge. Freeze deasserted: data_in is captured at the next capture edge, not immediately.
- Blank: an goes to 4'b1111 one clock after blank rises. The counter, index and shadow are unaffected. On deassert, display resumes at whatever index is current.
- Freeze and blank together: both apply independently. an=1111 means the dp indication is not visible.
- Reset mid-sweep: immediate all-off. After release, the sequence restarts at index 0 with shadow=0.
- First clock after reset release: an=4'b1110, seg=7'b1000000.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: a digit whose index is above the most significant nonzero nibble of shadow drives its anode high (dark). Its timing slot is still consumed. Digit 0 is always lit, so a value of 0 shows a single "0". Blanking is evaluated on the registered output path with the same one-clock lag.
- Undefined: all four digits are always lit unless blank is high.

Test Plan (REFRESH_CNT=4):
1. Hold rst low, toggle clk → an=1111, seg=1111111, dp=1. Release → next edge an=1110, seg=1000000; an then cycles 1110,1101,1011,0111, 4 clocks each.
2. data_in=16'h1234 from reset release → after 16 clocks shadow=1234. In the following sweep: digit0 seg=0011001 (4), digit1=0110000 (3), digit2=0100100 (2), digit3=1111001 (1).
3. After test 2, freeze=1 and data_in=16'hA5C0 → sweeps still show 1234, and dp=0 while an=1110. Drop freeze → next sweep shows digit0=1000000 (0), digit1=1000110 (C), digit2=0010010 (5), digit3=0001000 (A).
4. blank=1 for 6 clocks mid-sweep → an=1111 from the clock after assertion. On release, an resumes matching index = ((clocks since reset−1)/4) mod 4.
5. Assert rst during index 2 → outputs all-off within the same cycle, with no clock. Release → an=1110, and shadow reads 0 on every digit.
6. LEADING_ZERO_BLANK_EN defined:
   - data_in=16'h0030 → digit3 and digit2 have an high; digit1 seg=0110000 (3); digit0 seg=1000000 (0).
   - data_in=16'h0000 → only an[0] is ever low.
